// File: rtl/swdisp_pkg.sv
// Shared types and constants for the switch-event display scheduler.
package swdisp_pkg;

   // hexdigit codes above 15 select special glyphs
   typedef logic [4:0] disp_code_t;

   localparam disp_code_t CODE_ALL   = 5'd16;
   localparam disp_code_t CODE_DASH  = 5'd17;
   localparam disp_code_t CODE_UNDER = 5'd18;
   localparam disp_code_t CODE_S     = 5'd19;
   localparam disp_code_t CODE_OFF   = 5'd20;

   typedef enum logic [0:0] {StIdle, StShow} state_e;

   // Round-robin pick: first set bit of req searching upward from last+1 (mod 4).
   // Walking k downward lets the smallest distance overwrite the others.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-FF synchronizer plus counter-based debounce.
// chg_o is a combinational pulse on the edge where stable_q takes the new level,
// so the parent can record the event on that very edge.
module sw_debounce #(
   parameter int unsigned DEB_CNT = 120000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw_i,
   output logic stable_o,
   output logic chg_o,
   output logic lvl_o
);

   localparam int unsigned CntW = $clog2(DEB_CNT);

   logic [1:0]      sync_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync;

   assign sync = sync_q[1];

   // Synchronizer, counter and accepted level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], sw_raw_i};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Count cycles of disagreement; accept after DEB_CNT of them in a row
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      chg_o    = 1'b0;
      if (sync == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntW'(DEB_CNT - 1)) begin
         stable_d = sync;
         cnt_d    = '0;
         chg_o    = 1'b1;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   assign stable_o = stable_q;
   assign lvl_o    = sync;

endmodule

// File: rtl/swdisp_ctrl.sv
// Switch-event display scheduler: debounces four switches, drives the LEDs and
// time-shares the two-digit display between switch changes in round-robin order.
module swdisp_ctrl
   import swdisp_pkg::*;
#(
   parameter int unsigned DEB_CNT  = 120000,
   parameter int unsigned HOLD_CNT = 12000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       prswi,
   output logic [3:0]       prled,
   output disp_code_t       data_0,
   output disp_code_t       data_1,
   output logic             busy
);

   localparam int unsigned HoldW = $clog2(HOLD_CNT);

   logic [3:0]       stable, chg, new_lvl;
   state_e           state_q, state_d;
   logic [3:0]       pend_q, pend_d;
   logic [3:0]       lvl_q, lvl_d;
   logic [1:0]       idx_q, idx_d;
   logic             val_q, val_d;
   logic [1:0]       last_q, last_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             busy_d;
   disp_code_t       data0_q, data0_d, data1_q, data1_d;
   logic             grant;
   logic [1:0]       winner;

   for (genvar i = 0; i < 4; i++) begin : g_deb
      sw_debounce #(
         .DEB_CNT (DEB_CNT)
      ) u_deb (
         .clk      (clk),
         .rst_n    (rst_n),
         .sw_raw_i (prswi[i]),
         .stable_o (stable[i]),
         .chg_o    (chg[i]),
         .lvl_o    (new_lvl[i])
      );
   end

   assign prled = stable;

   // Scheduler state and registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pend_q  <= '0;
         lvl_q   <= '0;
         idx_q   <= '0;
         val_q   <= 1'b0;
         last_q  <= 2'd3;
         hold_q  <= '0;
         busy    <= 1'b0;
         data0_q <= CODE_OFF;
         data1_q <= CODE_OFF;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         lvl_q   <= lvl_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         busy    <= busy_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
      end
   end

   // FSM next state, grants and pending-event bookkeeping
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      idx_d   = idx_q;
      val_d   = val_q;
      last_d  = last_q;
      hold_d  = hold_q;
      grant   = 1'b0;
      winner  = rr_pick(pend_q, last_q);

      unique case (state_q)
         StIdle: begin
            if (|pend_q) grant = 1'b1;
         end
         StShow: begin
            if (hold_q == HoldW'(HOLD_CNT - 1)) begin
               if (|pend_q) grant = 1'b1;
               else state_d = StIdle;
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
      endcase

      if (grant) begin
         state_d        = StShow;
         idx_d          = winner;
         val_d          = lvl_q[winner];
         last_d         = winner;
         hold_d         = '0;
         pend_d[winner] = 1'b0;
      end

      // A new change on the same edge overrides the grant's clear
      pend_d = pend_d | chg;
      lvl_d  = (lvl_q & ~chg) | (new_lvl & chg);
   end

   // Display codes: the event being shown, else a summary of the switch state
   always_comb begin
      busy_d  = (state_d == StShow);
      data0_d = CODE_OFF;
      data1_d = CODE_OFF;
      if (state_d == StShow) begin
         data1_d = {3'b000, idx_d};
         data0_d = {4'b0000, val_d};
      end else begin
         case (stable)
            4'b0001: begin data1_d = CODE_S; data0_d = 5'd0;  end
            4'b0010: begin data1_d = CODE_S; data0_d = 5'd1;  end
            4'b0100: begin data1_d = CODE_S; data0_d = 5'd2;  end
            4'b1000: begin data1_d = CODE_S; data0_d = 5'd3;  end
            4'b1111: begin data1_d = CODE_S; data0_d = 5'hA;  end
            default: begin data1_d = CODE_OFF; data0_d = CODE_OFF; end
         endcase
      end
   end

   assign data_0 = data0_q;
   assign data_1 = data1_q;

endmodule

// File: tb/tb_swdisp_ctrl.sv
// Bench for swdisp_ctrl with DEB_CNT=4, HOLD_CNT=8.
module tb_swdisp_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] prswi = 4'b0000;
   logic [3:0] prled;
   logic [4:0] data_0, data_1;
   logic       busy;

   always #5 clk = ~clk;

   swdisp_ctrl #(
      .DEB_CNT  (DEB),
      .HOLD_CNT (HOLD)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .prswi  (prswi),
      .prled  (prled),
      .data_0 (data_0),
      .data_1 (data_1),
      .busy   (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: synchronized input is the raw input two edges late; a
   // switch is accepted after DEB consecutive disagreeing synchronized samples;
   // events are a per-switch pending flag plus latest level; each one is shown
   // for HOLD cycles.
   logic [3:0] m_sh1, m_sh2, m_stable, m_pend, m_lvl;
   int         m_run[4];
   bit         m_show;
   int         m_idx, m_shown, m_last;
   bit         m_val;
   logic [3:0] e_led;
   logic       e_busy;
   int         e_d0, e_d1;

   function automatic void model_reset();
      m_sh1 = 0; m_sh2 = 0; m_stable = 0; m_pend = 0; m_lvl = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_show = 0; m_idx = 0; m_val = 0; m_shown = 0; m_last = 3;
      e_led = 0; e_busy = 0; e_d0 = 20; e_d1 = 20;
   endfunction

   function automatic void model_step(input logic [3:0] sw);
      logic [3:0] old_stable, old_pend, old_lvl, chg;
      bit grant;
      int pick;
      old_stable = m_stable;
      old_pend   = m_pend;
      old_lvl    = m_lvl;
      chg        = 0;
      grant      = 0;
      pick       = -1;
      for (int i = 0; i < 4; i++) begin
         if (m_sh2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_stable[i] = m_sh2[i];
               m_run[i]    = 0;
               chg[i]      = 1;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_sh2 = m_sh1;
      m_sh1 = sw;
      if (!m_show) grant = (old_pend != 0);
      else if (m_shown == HOLD) begin
         if (old_pend != 0) grant = 1;
         else m_show = 0;
      end else m_shown++;
      if (grant) begin
         for (int k = 1; k <= 4; k++)
            if (pick < 0 && old_pend[(m_last + k) % 4]) pick = (m_last + k) % 4;
         m_show  = 1;
         m_idx   = pick;
         m_val   = old_lvl[pick];
         m_last  = pick;
         m_shown = 1;
         m_pend[pick] = 0;
      end
      for (int i = 0; i < 4; i++)
         if (chg[i]) begin
            m_pend[i] = 1;
            m_lvl[i]  = m_stable[i];
         end
      e_led  = m_stable;
      e_busy = m_show;
      if (m_show) begin
         e_d1 = m_idx;
         e_d0 = m_val;
      end else if ($countones(old_stable) == 1) begin
         e_d1 = 19;
         e_d0 = $clog2(old_stable);
      end else if (old_stable == 4'hF) begin
         e_d1 = 19;
         e_d0 = 10;
      end else begin
         e_d1 = 20;
         e_d0 = 20;
      end
   endfunction

   // One clock edge: advance the model, then compare just after the edge
   task automatic tick();
      @(posedge clk);
      model_step(prswi);
      #1;
      check("model_led", prled, e_led);
      check("model_busy", busy, e_busy);
      check("model_d1", data_1, e_d1);
      check("model_d0", data_0, e_d0);
   endtask

   // Assert reset mid-cycle, check outputs immediately, release after the edge
   task automatic do_reset(input logic [3:0] sw);
      #3;
      rst_n = 1'b0;
      prswi = sw;
      #1;
      check("rst_led", prled, 0);
      check("rst_d1", data_1, 20);
      check("rst_d0", data_0, 20);
      check("rst_busy", busy, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] sw;
      logic [3:0] led;
      logic [4:0] d1;
      logic [4:0] d0;
   } vec_t;

   vec_t vecs[6];
   int   dur;

   initial begin
      vecs[0] = '{sw: 4'b0001, led: 4'b0001, d1: 5'd19, d0: 5'd0};
      vecs[1] = '{sw: 4'b0011, led: 4'b0011, d1: 5'd20, d0: 5'd20};
      vecs[2] = '{sw: 4'b1111, led: 4'b1111, d1: 5'd19, d0: 5'd10};
      vecs[3] = '{sw: 4'b1000, led: 4'b1000, d1: 5'd19, d0: 5'd3};
      vecs[4] = '{sw: 4'b0000, led: 4'b0000, d1: 5'd20, d0: 5'd20};
      vecs[5] = '{sw: 4'b0100, led: 4'b0100, d1: 5'd19, d0: 5'd2};

      @(posedge clk);
      #1;
      do_reset(4'b0000);

      // Single event with exact latency and dwell
      prswi = 4'b0100;
      repeat (5) tick();
      check("t2_led_early", prled, 4'b0000);
      tick();
      check("t2_led", prled, 4'b0100);
      check("t2_busy_pre", busy, 0);
      tick();
      for (int c = 0; c < HOLD; c++) begin
         check("t2_busy", busy, 1);
         check("t2_d1", data_1, 2);
         check("t2_d0", data_0, 1);
         tick();
      end
      check("t2_idle_busy", busy, 0);
      check("t2_idle_d1", data_1, 19);
      check("t2_idle_d0", data_0, 2);

      // Glitch shorter than the debounce window
      prswi = 4'b0101;
      for (int c = 0; c < 13; c++) begin
         if (c == 3) prswi = 4'b0100;
         tick();
         check("t3_led", prled, 4'b0100);
         check("t3_busy", busy, 0);
      end

      // Simultaneous settle: served 0,1,2,3 back to back
      do_reset(4'b0000);
      prswi = 4'b1111;
      repeat (6) tick();
      check("t4_led", prled, 4'b1111);
      tick();
      for (int k = 0; k < 4 * HOLD; k++) begin
         check("t4_busy", busy, 1);
         check("t4_d1", data_1, k / HOLD);
         check("t4_d0", data_0, 1);
         tick();
      end
      check("t4_idle_busy", busy, 0);
      check("t4_idle_d1", data_1, 19);
      check("t4_idle_d0", data_0, 10);

      // Coalescing: switch 1 on then off while switch 0 is displayed
      do_reset(4'b0000);
      prswi = 4'b0001;
      repeat (3) tick();
      prswi = 4'b0011;
      repeat (4) tick();
      prswi = 4'b0001;
      check("t5_sw0_d1", data_1, 0);
      check("t5_sw0_busy", busy, 1);
      repeat (8) tick();
      check("t5_sw1_busy", busy, 1);
      check("t5_sw1_d1", data_1, 1);
      check("t5_sw1_d0", data_0, 0);
      repeat (8) tick();
      check("t5_idle_busy", busy, 0);
      check("t5_idle_d1", data_1, 19);
      check("t5_idle_d0", data_0, 0);

      // Reset while showing with two events pending
      do_reset(4'b0000);
      prswi = 4'b0111;
      repeat (7) tick();
      check("t6_busy", busy, 1);
      repeat (2) tick();
      do_reset(4'b0000);
      repeat (40) tick();
      check("t6_after_busy", busy, 0);
      check("t6_after_d1", data_1, 20);
      check("t6_after_d0", data_0, 20);

      // Table of settled patterns
      for (int v = 0; v < 6; v++) begin
         prswi = vecs[v].sw;
         repeat (50) tick();
         check("tbl_led", prled, vecs[v].led);
         check("tbl_busy", busy, 0);
         check("tbl_d1", data_1, vecs[v].d1);
         check("tbl_d0", data_0, vecs[v].d0);
      end

      // Random switch activity against the model
      do_reset(4'b0000);
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) prswi = 4'($urandom);
         else prswi = prswi ^ (4'b0001 << $urandom_range(0, 3));
         dur = $urandom_range(1, 12);
         repeat (dur) tick();
      end
      repeat (60) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
